fp_wb_arbiter: RTL and testbench
================================

Name: fp_wb_arbiter

Overview:
Parametrised successor to the single-source FP write-back stage. Merges NUM_SRC write-back producers onto the single FP register-file write port, such as the pipelined FPU, FP loads and the iterative FDIV/FSQRT unit. It uses a valid/ready handshake per source and fixed priority with a starvation guard. The output is registered (1-cycle latency), and the block sits between the FP execute/memory stages and the FP register file.

Parameters:
NUM_SRC, 3, number of write-back sources; index 0 is the highest base priority.
DATA_W, 32, write-back data width.
RD_W, 5, destination register index width.
MAX_WAIT, 4, consecutive lost arbitration cycles after which a source is promoted; range 1..255.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
src_valid  input  NUM_SRC  per-source request.
src_data  input  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
src_rd  input  NUM_SRC*RD_W  per-source destination; source i occupies bits [i*RD_W +: RD_W].
src_ready  output  NUM_SRC  combinational grant; a transfer occurs when valid & ready.
wb_hold  input  1  write port borrowed elsewhere; no grants are issued while it is high.
wb_data  output  DATA_W  registered write data.
wb_rd  output  RD_W  registered destination.
wb_we  output  1  registered write enable.
starve_flag  output  NUM_SRC  registered; bit i high while source i is promoted.

Behaviour:
- Reset (rst_n low, async): wb_data=0, wb_rd=0, wb_we=0, starve_flag=0, all wait counters=0. src_ready=0 while in reset.
- Handshake: a source asserting valid holds data/rd stable until ready. src_ready is one-hot or zero and never depends on itself.
- Grant selection (combinational):
  - If wb_hold=1, no grant.
  - Else, if any valid source has its starve bit set, grant the lowest-index such source.
  - Else, grant the lowest-index valid source.
  - Else, no grant.
- Latency: a source granted in cycle N produces wb_we=1, wb_data and wb_rd from that source in cycle N+1.
- No grant in cycle N: wb_we=0 in N+1, and wb_data/wb_rd retain their previous values.
- Back-to-back grants on consecutive cycles yield a continuous wb_we=1 at full throughput of 1 write/cycle.
- Wait counter i (width clog2(MAX_WAIT+1)):
  - Increments when src_valid[i]=1 and it is not granted and wb_hold=0.
  - Saturates at MAX_WAIT.
  - Clears on a grant to i, or when src_valid[i]=0.
  - Holds its value during wb_hold.
- starve_flag[i] is set in the cycle after counter i reaches MAX_WAIT. It clears in the cycle after source i is granted or drops valid.
- Multiple starved sources: the lowest index wins. The others keep their flags and are served in index order on following cycles.
- rd has no special value: f0 is a writable register, so rd=0 is written normally.
- Same rd from two sources in one cycle: only the granted one is written. The loser writes later, and the last write wins. Ordering is the producers' responsibility.
- wb_hold asserted mid-stream: a write already registered still appears (wb_we=1 for exactly that cycle). Subsequent cycles show wb_we=0 until hold drops.
- Reset mid-operation: pending requests are dropped; the producers re-present after reset.

Decomposition:
- Shared fp_pkg: constants FP_DATA_W=32 and FP_RD_W=5, and source index constants SRC_FPU=0, SRC_LOAD=1, SRC_DIV=2.
- One sub-module is natural: fp_wb_prio_sel. It is a combinational fixed-priority one-hot selector of width NUM_SRC, instanced twice (starved-valid vector and plain-valid vector), with an any-bit output.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with src_valid=3'b111. Expect all outputs 0 immediately (async) and src_ready=0. After release, the first grant goes to src0.
- Single source: src1 valid, data=32'h3F800000, rd=5'd7, for 1 cycle. Expect src_ready=3'b010. The next cycle shows wb_we=1, wb_data=32'h3F800000, wb_rd=7; the cycle after shows wb_we=0 and wb_data still 32'h3F800000.
- Priority: src0 and src2 valid together (rd=3 and rd=9). Expect src0 written first with rd=3 and src2 the next cycle with rd=9, with wb_we high for 2 consecutive cycles.
- Starvation (MAX_WAIT=4): src0 valid continuously with changing data, src2 valid constant. src2 loses 4 cycles, then starve_flag[2] rises. src2 is granted on the next cycle, and its flag clears one cycle after the grant.
- Hold: src0 valid, wb_hold=1 for 3 cycles. Expect src_ready=0 and wb_we=0 throughout, with counters frozen. The grant comes in the cycle hold drops, and the write follows 1 cycle later.
- rd=0 write: src2 writes data=32'hFFFFFFFF to rd=0. Expect wb_we=1 and wb_rd=0, with no suppression.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg
// Shared FP write-back constants: default data and destination widths, and
// the source index assignment used when wiring producers onto the arbiter.
// No ports; imported by the arbiter interface and modules.
package fp_pkg;

  localparam int FP_DATA_W  = 32;
  localparam int FP_RD_W    = 5;

  // Source indices; a lower index has a higher base priority.
  localparam int SRC_FPU    = 0;
  localparam int SRC_LOAD   = 1;
  localparam int SRC_DIV    = 2;
  localparam int FP_NUM_SRC = 3;

  // Width of a wait counter that has to reach max_wait.
  function automatic int wait_cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// fp_wb_arbiter_if
// Bundles the per-source valid/ready/data/rd request bus, the hold input and
// the registered write-port outputs of the FP write-back arbiter.
//   master : producer/register-file side (drives requests and wb_hold)
//   slave  : arbiter side (drives src_ready and the write port)
interface fp_wb_arbiter_if
  import fp_pkg::*;
#(
  parameter int NUM_SRC = FP_NUM_SRC,
  parameter int DATA_W  = FP_DATA_W,
  parameter int RD_W    = FP_RD_W
);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*RD_W-1:0]   src_rd;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      wb_hold;
  logic [DATA_W-1:0]         wb_data;
  logic [RD_W-1:0]           wb_rd;
  logic                      wb_we;
  logic [NUM_SRC-1:0]        starve_flag;

  modport master (
    output src_valid, src_data, src_rd, wb_hold,
    input  src_ready, wb_data, wb_rd, wb_we, starve_flag
  );

  modport slave (
    input  src_valid, src_data, src_rd, wb_hold,
    output src_ready, wb_data, wb_rd, wb_we, starve_flag
  );

endinterface

// File: rtl/fp_wb_prio_sel.sv
// fp_wb_prio_sel
// Combinational fixed-priority selector: bit 0 has the highest priority.
//   req   : request vector
//   grant : one-hot lowest-index set bit of req, or zero
//   any   : high when any request bit is set
module fp_wb_prio_sel #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             any
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter
// Merges NUM_SRC FP write-back producers onto the single register-file write
// port. Fixed priority (index 0 highest) with a per-source starvation guard:
// a source that loses MAX_WAIT consecutive arbitrations is promoted above all
// non-promoted sources. The write port is registered (1-cycle latency).
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of fp_wb_arbiter_if (requests, src_ready grant,
//                wb_hold, wb_data/wb_rd/wb_we, starve_flag)
module fp_wb_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_SRC  = FP_NUM_SRC,
  parameter int DATA_W   = FP_DATA_W,
  parameter int RD_W     = FP_RD_W,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_wb_arbiter_if.slave  bus
);

  localparam int               CNT_W   = wait_cnt_w(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [NUM_SRC-1:0] starve_q;
  logic [CNT_W-1:0]   wait_q [NUM_SRC];
  logic [DATA_W-1:0]  wb_data_q;
  logic [RD_W-1:0]    wb_rd_q;
  logic               wb_we_q;

  logic [NUM_SRC-1:0] starve_gnt, plain_gnt, grant;
  logic               starve_any, plain_any;
  logic [DATA_W-1:0]  sel_data;
  logic [RD_W-1:0]    sel_rd;

  // Promoted requesters are resolved first; the plain vector is the fallback.
  fp_wb_prio_sel #(.WIDTH(NUM_SRC)) u_sel_starved (
    .req   (bus.src_valid & starve_q),
    .grant (starve_gnt),
    .any   (starve_any)
  );

  fp_wb_prio_sel #(.WIDTH(NUM_SRC)) u_sel_plain (
    .req   (bus.src_valid),
    .grant (plain_gnt),
    .any   (plain_any)
  );

  // rst_n gates the grant so no producer sees ready while in reset.
  always_comb begin
    grant = '0;
    if (rst_n && !bus.wb_hold) begin
      if (starve_any)     grant = starve_gnt;
      else if (plain_any) grant = plain_gnt;
    end
  end

  // The grant is one-hot, so at most one source drives the mux.
  always_comb begin
    sel_data = '0;
    sel_rd   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_data = bus.src_data[i*DATA_W +: DATA_W];
        sel_rd   = bus.src_rd[i*RD_W +: RD_W];
      end
    end
  end

  // The starve flag is set on the same edge the counter lands on MAX_WAIT, so
  // it tracks "counter saturated" and is visible the cycle after the last loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      starve_q  <= '0;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= '0;
    end else begin
      wb_we_q <= |grant;
      if (|grant) begin
        wb_data_q <= sel_data;
        wb_rd_q   <= sel_rd;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant[i] || !bus.src_valid[i]) begin
          wait_q[i]   <= '0;
          starve_q[i] <= 1'b0;
        end else if (!bus.wb_hold) begin
          if (wait_q[i] != CNT_MAX) wait_q[i] <= wait_q[i] + 1'b1;
          if (wait_q[i] >= CNT_MAX - 1'b1) starve_q[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.src_ready   = grant;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.starve_flag = starve_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter
// Self-checking bench for fp_wb_arbiter: a directed vector table, a
// mid-operation asynchronous reset sequence, and constrained-random traffic
// compared against a per-source wait-count reference model.
module tb_fp_wb_arbiter;

  localparam int NUM = 3;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int MW  = 4;

  logic clk;
  logic rst_n;

  fp_wb_arbiter_if #(.NUM_SRC(NUM), .DATA_W(DW), .RD_W(RW)) bus ();

  fp_wb_arbiter #(.NUM_SRC(NUM), .DATA_W(DW), .RD_W(RW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: write-port registers plus consecutive-loss count.
  logic          m_we;
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_rd;
  int            m_wait [NUM];
  logic [NUM-1:0] last_grant;

  logic [NUM-1:0]    cur_valid;
  logic [NUM*DW-1:0] cur_data;
  logic [NUM*RW-1:0] cur_rd;
  logic              cur_hold;

  typedef struct {
    logic [NUM-1:0]    valid;
    logic [NUM*DW-1:0] data;
    logic [NUM*RW-1:0] rd;
    logic              hold;
    logic [NUM-1:0]    ready;
    logic              we;
    logic [DW-1:0]     wdata;
    logic [RW-1:0]     wrd;
    logic [NUM-1:0]    starve;
  } vec_t;

  vec_t vecs [29];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NUM-1:0] modelGrant(input logic [NUM-1:0] v, input logic h);
    if (h) return '0;
    for (int i = 0; i < NUM; i++)
      if (v[i] && m_wait[i] >= MW) return NUM'(1) << i;
    for (int i = 0; i < NUM; i++)
      if (v[i]) return NUM'(1) << i;
    return '0;
  endfunction

  function automatic logic [NUM-1:0] modelStarve();
    logic [NUM-1:0] s;
    for (int i = 0; i < NUM; i++) s[i] = (m_wait[i] >= MW);
    return s;
  endfunction

  task automatic modelReset();
    m_we = 1'b0;
    m_data = '0;
    m_rd = '0;
    last_grant = '0;
    for (int i = 0; i < NUM; i++) m_wait[i] = 0;
  endtask

  task automatic modelStep();
    logic [NUM-1:0] g;
    g = modelGrant(cur_valid, cur_hold);
    m_we = |g;
    for (int i = 0; i < NUM; i++) begin
      if (g[i]) begin
        m_data = cur_data[i*DW +: DW];
        m_rd   = cur_rd[i*RW +: RW];
      end
      if (g[i] || !cur_valid[i]) m_wait[i] = 0;
      else if (!cur_hold && m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
    end
    last_grant = g;
  endtask

  task automatic applyStimulus(input logic [NUM-1:0] v, input logic [NUM*DW-1:0] d,
                               input logic [NUM*RW-1:0] r, input logic h);
    cur_valid = v;
    cur_data  = d;
    cur_rd    = r;
    cur_hold  = h;
    bus.src_valid = v;
    bus.src_data  = d;
    bus.src_rd    = r;
    bus.wb_hold   = h;
    @(negedge clk);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.src_ready), 32'(modelGrant(cur_valid, cur_hold)));
    checkOutput({tag, "_we"}, 32'(bus.wb_we), 32'(m_we));
    checkOutput({tag, "_data"}, bus.wb_data, m_data);
    checkOutput({tag, "_rd"}, 32'(bus.wb_rd), 32'(m_rd));
    checkOutput({tag, "_starve"}, 32'(bus.starve_flag), 32'(modelStarve()));
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] DA = 32'h40000000;
  localparam logic [31:0] DB = 32'h40400000;
  localparam logic [31:0] DC = 32'hC0A00000;
  localparam logic [31:0] DE = 32'h0000BEEF;
  localparam logic [31:0] F1 = 32'h12345678;
  localparam logic [31:0] F2 = 32'h9ABCDEF0;
  localparam logic [31:0] DF = 32'hFFFFFFFF;
  localparam logic [31:0] ON = 32'h3F800000;

  initial begin
    // Directed table: inputs for one cycle and the outputs seen in that cycle.
    vecs[0]  = '{3'b010, {Z, ON, Z}, {5'd0, 5'd7, 5'd0}, 1'b0, 3'b010, 1'b0, Z, 5'd0, 3'b000};
    vecs[1]  = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b1, ON, 5'd7, 3'b000};
    vecs[2]  = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b0, ON, 5'd7, 3'b000};
    vecs[3]  = '{3'b101, {DB, Z, DA}, {5'd9, 5'd0, 5'd3}, 1'b0, 3'b001, 1'b0, ON, 5'd7, 3'b000};
    vecs[4]  = '{3'b100, {DB, Z, Z}, {5'd9, 5'd0, 5'd0}, 1'b0, 3'b100, 1'b1, DA, 5'd3, 3'b000};
    vecs[5]  = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b1, DB, 5'd9, 3'b000};
    vecs[6]  = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b0, DB, 5'd9, 3'b000};
    vecs[7]  = '{3'b101, {DC, Z, 32'h11110000}, {5'd4, 5'd0, 5'd1}, 1'b0, 3'b001, 1'b0, DB, 5'd9, 3'b000};
    vecs[8]  = '{3'b101, {DC, Z, 32'h11110001}, {5'd4, 5'd0, 5'd1}, 1'b0, 3'b001, 1'b1, 32'h11110000, 5'd1, 3'b000};
    vecs[9]  = '{3'b101, {DC, Z, 32'h11110002}, {5'd4, 5'd0, 5'd1}, 1'b0, 3'b001, 1'b1, 32'h11110001, 5'd1, 3'b000};
    vecs[10] = '{3'b101, {DC, Z, 32'h11110003}, {5'd4, 5'd0, 5'd1}, 1'b0, 3'b001, 1'b1, 32'h11110002, 5'd1, 3'b000};
    vecs[11] = '{3'b101, {DC, Z, 32'h11110004}, {5'd4, 5'd0, 5'd1}, 1'b0, 3'b100, 1'b1, 32'h11110003, 5'd1, 3'b100};
    vecs[12] = '{3'b001, {Z, Z, 32'h11110004}, {5'd0, 5'd0, 5'd1}, 1'b0, 3'b001, 1'b1, DC, 5'd4, 3'b000};
    vecs[13] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b1, 32'h11110004, 5'd1, 3'b000};
    vecs[14] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b0, 32'h11110004, 5'd1, 3'b000};
    vecs[15] = '{3'b001, {Z, Z, DE}, {5'd0, 5'd0, 5'd2}, 1'b1, 3'b000, 1'b0, 32'h11110004, 5'd1, 3'b000};
    vecs[16] = '{3'b001, {Z, Z, DE}, {5'd0, 5'd0, 5'd2}, 1'b1, 3'b000, 1'b0, 32'h11110004, 5'd1, 3'b000};
    vecs[17] = '{3'b001, {Z, Z, DE}, {5'd0, 5'd0, 5'd2}, 1'b1, 3'b000, 1'b0, 32'h11110004, 5'd1, 3'b000};
    vecs[18] = '{3'b001, {Z, Z, DE}, {5'd0, 5'd0, 5'd2}, 1'b0, 3'b001, 1'b0, 32'h11110004, 5'd1, 3'b000};
    vecs[19] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b1, DE, 5'd2, 3'b000};
    vecs[20] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b0, DE, 5'd2, 3'b000};
    vecs[21] = '{3'b100, {DF, Z, Z}, 15'd0, 1'b0, 3'b100, 1'b0, DE, 5'd2, 3'b000};
    vecs[22] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b1, DF, 5'd0, 3'b000};
    vecs[23] = '{3'b001, {Z, Z, F1}, {5'd0, 5'd0, 5'd5}, 1'b0, 3'b001, 1'b0, DF, 5'd0, 3'b000};
    vecs[24] = '{3'b001, {Z, Z, F2}, {5'd0, 5'd0, 5'd5}, 1'b1, 3'b000, 1'b1, F1, 5'd5, 3'b000};
    vecs[25] = '{3'b001, {Z, Z, F2}, {5'd0, 5'd0, 5'd5}, 1'b1, 3'b000, 1'b0, F1, 5'd5, 3'b000};
    vecs[26] = '{3'b001, {Z, Z, F2}, {5'd0, 5'd0, 5'd5}, 1'b0, 3'b001, 1'b0, F1, 5'd5, 3'b000};
    vecs[27] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b1, F2, 5'd5, 3'b000};
    vecs[28] = '{3'b000, {Z, Z, Z}, 15'd0, 1'b0, 3'b000, 1'b0, F2, 5'd5, 3'b000};

    rst_n = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_rd    = '0;
    bus.wb_hold   = 1'b0;
    cur_valid = '0;
    cur_data  = '0;
    cur_rd    = '0;
    cur_hold  = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int k = 0; k < 29; k++) begin
      applyStimulus(vecs[k].valid, vecs[k].data, vecs[k].rd, vecs[k].hold);
      checkOutput($sformatf("row%0d_ready", k), 32'(bus.src_ready), 32'(vecs[k].ready));
      checkOutput($sformatf("row%0d_we", k), 32'(bus.wb_we), 32'(vecs[k].we));
      checkOutput($sformatf("row%0d_data", k), bus.wb_data, vecs[k].wdata);
      checkOutput($sformatf("row%0d_rd", k), 32'(bus.wb_rd), 32'(vecs[k].wrd));
      checkOutput($sformatf("row%0d_starve", k), 32'(bus.starve_flag), 32'(vecs[k].starve));
      advance();
    end

    // Mid-operation reset with every source requesting.
    applyStimulus(3'b111, {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0},
                  {5'd12, 5'd11, 5'd10}, 1'b0);
    checkModel("prereset");
    advance();
    checkOutput("prereset_we_high", 32'(bus.wb_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_we", 32'(bus.wb_we), 32'd0);
    checkOutput("async_rst_data", bus.wb_data, 32'd0);
    checkOutput("async_rst_rd", 32'(bus.wb_rd), 32'd0);
    checkOutput("async_rst_starve", 32'(bus.starve_flag), 32'd0);
    checkOutput("async_rst_ready", 32'(bus.src_ready), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("in_rst_ready", 32'(bus.src_ready), 32'd0);
    checkOutput("in_rst_we", 32'(bus.wb_we), 32'd0);
    #2 rst_n = 1'b1;
    applyStimulus(cur_valid, cur_data, cur_rd, cur_hold);
    checkOutput("post_rst_first_grant", 32'(bus.src_ready), 32'b001);
    checkModel("postreset");
    advance();

    // Random traffic; producers hold requests stable until granted.
    for (int n = 0; n < 600; n++) begin
      logic [NUM-1:0]    nv;
      logic [NUM*DW-1:0] nd;
      logic [NUM*RW-1:0] nr;
      logic              nh;
      nd = cur_data;
      nr = cur_rd;
      for (int i = 0; i < NUM; i++) begin
        if (cur_valid[i] && !last_grant[i]) begin
          nv[i] = 1'b1;
        end else if ($urandom_range(0, 99) < ((i == 0) ? 75 : 45)) begin
          nv[i] = 1'b1;
          nd[i*DW +: DW] = $urandom;
          nr[i*RW +: RW] = RW'($urandom_range(0, 31));
        end else begin
          nv[i] = 1'b0;
        end
      end
      nh = ($urandom_range(0, 99) < 15);
      applyStimulus(nv, nd, nr, nh);
      checkModel($sformatf("rand%0d", n));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
